// File: rtl/be_clock_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | be_clock_ctrl_if : control/status bundle of the clock controller |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface be_clock_ctrl_if #(
    parameter int DIV_W = 3,
    parameter int CNT_W = 8
);
    logic [1:0]       MODE;
    logic             CLK_STEP;
    logic             HLT;
    logic [DIV_W-1:0] DIV_CLK;
    logic [CNT_W-1:0] BURST_LEN;
    logic             CLK;
    logic             NOT_CLK;
    logic             CLK_RISE;
    logic             BUSY;
    logic             HALTED;

    modport master (
        output MODE, CLK_STEP, HLT, DIV_CLK, BURST_LEN,
        input  CLK, NOT_CLK, CLK_RISE, BUSY, HALTED
    );

    modport slave (
        input  MODE, CLK_STEP, HLT, DIV_CLK, BURST_LEN,
        output CLK, NOT_CLK, CLK_RISE, BUSY, HALTED
    );
endinterface
`default_nettype wire

// File: rtl/be_clock_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | be_clock_ctrl : run/step/burst/halt clock generator for a CPU    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module be_clock_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int BASE_HZ    = 1,
    parameter int DIV_W      = 3,
    parameter int CNT_W      = 8,
    parameter int DEB_CYCLES = 500000
) (
    input wire              iCLK,
    input wire              iRST_N,
    be_clock_ctrl_if.slave  bus
);
    localparam int c_half_base = CLK_HZ / (2 * BASE_HZ);
    localparam int c_hcnt_w    = $clog2(c_half_base + 1);
    localparam int c_deb_w     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    localparam logic [c_hcnt_w-1:0] c_half_base_v = c_hcnt_w'(c_half_base);
    localparam logic [c_hcnt_w-1:0] c_hcnt_one    = c_hcnt_w'(1);
    localparam logic [c_deb_w-1:0]  c_deb_last    = c_deb_w'(DEB_CYCLES - 1);
    localparam logic [c_deb_w-1:0]  c_deb_one     = c_deb_w'(1);
    localparam logic [CNT_W-1:0]    c_burst_one   = CNT_W'(1);

    generate
        if ((c_half_base >> ((1 << DIV_W) - 1)) < 1) begin : g_param_err
            $error("be_clock_ctrl: half period below one iCLK cycle at the fastest DIV_CLK");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_STEP_HI = 3'd2,
        ST_STEP_LO = 3'd3,
        ST_BURST   = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_clk;
    logic                r_rise;
    logic                r_busy;
    logic                r_halted;
    logic [c_hcnt_w-1:0] r_hcnt;
    logic [DIV_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_burst;
    logic [1:0]          r_sync;
    logic                r_deb_level;
    logic [c_deb_w-1:0]  r_deb_cnt;

    logic [c_hcnt_w-1:0] w_half_len;
    logic                w_half_tick;
    logic                w_deb_done;
    logic                w_step_evt;
    logic                w_halt_req;

    assign w_half_len  = c_half_base_v >> r_div;
    assign w_half_tick = (r_hcnt == (w_half_len - c_hcnt_one));
    assign w_deb_done  = (r_sync[1] != r_deb_level) && (r_deb_cnt == c_deb_last);
    assign w_step_evt  = w_deb_done && r_sync[1];
    assign w_halt_req  = r_halted || bus.HLT;

    // Debounce: a new level is accepted after DEB_CYCLES consecutive samples of it.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_sync      <= 2'b00;
            r_deb_level <= 1'b0;
            r_deb_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], bus.CLK_STEP};
            if (r_sync[1] == r_deb_level) begin
                r_deb_cnt <= '0;
            end else if (w_deb_done) begin
                r_deb_level <= r_sync[1];
                r_deb_cnt   <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + c_deb_one;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state  <= ST_IDLE;
            r_clk    <= 1'b0;
            r_rise   <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_hcnt   <= '0;
            r_div    <= '0;
            r_burst  <= '0;
        end else begin
            r_rise <= 1'b0;
            if (bus.HLT) begin
                r_halted <= 1'b1;
            end
            // The rate is only re-sampled where a phase ends, so no phase is stretched or cut.
            if (r_state == ST_IDLE || w_half_tick) begin
                r_div <= bus.DIV_CLK;
            end
            if (r_state == ST_IDLE || r_state == ST_HALT || w_half_tick) begin
                r_hcnt <= '0;
            end else begin
                r_hcnt <= r_hcnt + c_hcnt_one;
            end

            if (r_state == ST_HALT) begin
                r_clk  <= 1'b0;
                r_busy <= 1'b0;
            end else if (w_halt_req && (r_state == ST_IDLE || !r_clk || w_half_tick)) begin
                // A pending halt lets the current high phase run to its end first.
                r_state <= ST_HALT;
                r_clk   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_clk <= 1'b0;
                        if (bus.MODE == 2'b00) begin
                            r_state <= ST_RUN;
                        end else if (w_step_evt && bus.MODE == 2'b01) begin
                            r_state <= ST_STEP_HI;
                            r_clk   <= 1'b1;
                            r_rise  <= 1'b1;
                            r_busy  <= 1'b1;
                        end else if (w_step_evt && bus.MODE == 2'b10 && bus.BURST_LEN != '0) begin
                            r_state <= ST_BURST;
                            r_burst <= bus.BURST_LEN;
                            r_clk   <= 1'b1;
                            r_rise  <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_half_tick) begin
                            if (r_clk) begin
                                r_clk <= 1'b0;
                            end else if (bus.MODE != 2'b00) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_clk  <= 1'b1;
                                r_rise <= 1'b1;
                            end
                        end
                    end
                    ST_STEP_HI: begin
                        if (w_half_tick) begin
                            r_state <= ST_STEP_LO;
                            r_clk   <= 1'b0;
                        end
                    end
                    ST_STEP_LO: begin
                        if (w_half_tick) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_BURST: begin
                        if (w_half_tick) begin
                            if (r_clk) begin
                                r_clk <= 1'b0;
                            end else if (r_burst == c_burst_one) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_burst <= r_burst - c_burst_one;
                                r_clk   <= 1'b1;
                                r_rise  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_clk   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.CLK      = r_clk;
    assign bus.NOT_CLK  = ~r_clk;
    assign bus.CLK_RISE = r_rise;
    assign bus.BUSY     = r_busy;
    assign bus.HALTED   = r_halted;
endmodule
`default_nettype wire

// File: tb/tb_be_clock_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_be_clock_ctrl : self-checking bench for be_clock_ctrl         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_be_clock_ctrl;
    localparam int C_HALF_BASE = 8;   // CLK_HZ / (2 * BASE_HZ) for the bench parameters
    localparam int C_DEB       = 4;
    localparam int C_WINDOW    = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    int   m_rises, m_edges, m_rise_bad, m_inv_err, m_busy, m_hmin, m_hmax, m_hrun;
    logic prev_clk;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] div;
        logic [3:0] blen;
        int         press;
        int         rises;
        int         half;
        int         busy;
    } vec_t;

    vec_t tbl[8];

    be_clock_ctrl_if #(.DIV_W(2), .CNT_W(4)) bus ();

    be_clock_ctrl #(
        .CLK_HZ    (16),
        .BASE_HZ   (1),
        .DIV_W     (2),
        .CNT_W     (4),
        .DEB_CYCLES(C_DEB)
    ) dut (
        .iCLK  (clk),
        .iRST_N(rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.CLK_STEP = 1'b0;
        bus.HLT      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic clear_meas();
        m_rises = 0; m_edges = 0; m_rise_bad = 0; m_inv_err = 0;
        m_busy = 0; m_hmin = 1000; m_hmax = 0; m_hrun = 0;
        prev_clk = bus.CLK;
    endtask

    task automatic observe();
        if (bus.NOT_CLK !== ~bus.CLK) m_inv_err++;
        if (bus.CLK && !prev_clk) m_edges++;
        if (bus.CLK_RISE) begin
            m_rises++;
            if (!(bus.CLK && !prev_clk)) m_rise_bad++;
        end
        if (bus.BUSY) m_busy++;
        if (bus.CLK) begin
            m_hrun++;
        end else if (prev_clk) begin
            if (m_hrun < m_hmin) m_hmin = m_hrun;
            if (m_hrun > m_hmax) m_hmax = m_hrun;
            m_hrun = 0;
        end
        prev_clk = bus.CLK;
    endtask

    // Press the step button for v.press cycles and compare the resulting waveform.
    task automatic run_case(input string tag, input vec_t v);
        bus.MODE      = v.mode;
        bus.DIV_CLK   = v.div;
        bus.BURST_LEN = v.blen;
        do_reset();
        clear_meas();
        bus.CLK_STEP = 1'b1;
        for (int i = 0; i < C_WINDOW; i++) begin
            if (i == v.press) bus.CLK_STEP = 1'b0;
            tick();
            observe();
        end
        check({tag, "_rises"}, m_rises, v.rises);
        check({tag, "_edges"}, m_edges, v.rises);
        check({tag, "_rise_align"}, m_rise_bad, 0);
        check({tag, "_not_clk"}, m_inv_err, 0);
        check({tag, "_busy_cycles"}, m_busy, v.busy);
        check({tag, "_end_clk"}, int'(bus.CLK), 0);
        if (v.rises > 0) begin
            check({tag, "_high_min"}, m_hmin, v.half);
            check({tag, "_high_max"}, m_hmax, v.half);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t       rv;
        int         plen, pexp, overrun, hl;
        bit         pval, found;
        logic [1:0] seen;
        int         periods;

        bus.MODE      = 2'b11;
        bus.DIV_CLK   = 2'd0;
        bus.BURST_LEN = 4'd0;
        bus.CLK_STEP  = 1'b0;
        bus.HLT       = 1'b0;

        // Reset state
        do_reset();
        check("rst_clk",      int'(bus.CLK),      0);
        check("rst_not_clk",  int'(bus.NOT_CLK),  1);
        check("rst_clk_rise", int'(bus.CLK_RISE), 0);
        check("rst_busy",     int'(bus.BUSY),     0);
        check("rst_halted",   int'(bus.HALTED),   0);

        // {mode, div, burst_len, press cycles, rises, half length, busy cycles}
        tbl[0] = '{2'b01, 2'd0, 4'd0, 10, 1, 8, 16};
        tbl[1] = '{2'b01, 2'd0, 4'd0,  2, 0, 0,  0};
        tbl[2] = '{2'b10, 2'd0, 4'd3, 10, 3, 8, 48};
        tbl[3] = '{2'b10, 2'd0, 4'd0, 10, 0, 0,  0};
        tbl[4] = '{2'b10, 2'd3, 4'd2, 10, 2, 1,  4};
        tbl[5] = '{2'b11, 2'd0, 4'd3, 10, 0, 0,  0};
        tbl[6] = '{2'b01, 2'd2, 4'd0, 10, 1, 2,  4};
        tbl[7] = '{2'b10, 2'd1, 4'd4, 10, 4, 4, 32};
        for (int k = 0; k < 8; k++) begin
            run_case($sformatf("tbl%0d", k), tbl[k]);
        end

        // Randomised step/burst cases against the period-counting model
        for (int k = 0; k < 12; k++) begin
            rv.mode  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            rv.blen  = 4'($urandom_range(0, 5));
            rv.div   = 2'($urandom_range(0, 3));
            rv.press = $urandom_range(1, 8);
            if (rv.press < C_DEB)       periods = 0;
            else if (rv.mode == 2'b01)  periods = 1;
            else                        periods = int'(rv.blen);
            rv.rises = periods;
            rv.half  = C_HALF_BASE >> rv.div;
            rv.busy  = 2 * rv.half * periods;
            run_case($sformatf("rnd%0d", k), rv);
        end

        // Continuous mode: each phase length follows the rate seen at the edge that began it
        bus.MODE    = 2'b00;
        bus.DIV_CLK = 2'd0;
        do_reset();
        clear_meas();
        plen = 0; pexp = 0; pval = 1'b0; overrun = 0;
        for (int c = 0; c < 700; c++) begin
            if (c == 60)
                bus.DIV_CLK = 2'd3;
            else if (c >= 100 && $urandom_range(0, 11) == 0)
                bus.DIV_CLK = 2'($urandom_range(0, 3));
            seen = bus.DIV_CLK;
            tick();
            if (bus.CLK !== prev_clk) begin
                if (pval) check("run_phase_len", plen, pexp);
                pexp = C_HALF_BASE >> seen;
                plen = 1;
                pval = 1'b1;
            end else begin
                plen++;
                if (pval && plen > pexp) overrun++;
            end
            observe();
        end
        check("run_overrun", overrun, 0);
        check("run_rise_count", m_rises, m_edges);
        check("run_rise_align", m_rise_bad, 0);
        check("run_not_clk", m_inv_err, 0);
        check("run_enough_edges", int'(m_edges >= 40), 1);

        // MODE change mid high phase: the phase runs its full length, then CLK stays low
        bus.MODE    = 2'b00;
        bus.DIV_CLK = 2'd0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (bus.CLK) found = 1'b1;
        end
        check("modechg_started", int'(found), 1);
        hl = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.CLK) hl++;
        end
        bus.MODE = 2'b11;
        for (int i = 0; i < 20 && bus.CLK; i++) begin
            tick();
            if (bus.CLK) hl++;
        end
        check("modechg_high_len", hl, 8);
        clear_meas();
        for (int i = 0; i < 40; i++) begin
            tick();
            observe();
        end
        check("modechg_no_rises", m_edges, 0);
        check("modechg_clk_low", int'(bus.CLK), 0);

        // Halt during the first high phase of a burst
        bus.MODE      = 2'b10;
        bus.DIV_CLK   = 2'd0;
        bus.BURST_LEN = 4'd3;
        do_reset();
        bus.CLK_STEP = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.CLK) found = 1'b1;
        end
        check("halt_burst_started", int'(found), 1);
        bus.CLK_STEP = 1'b0;
        hl = 1;
        tick();
        if (bus.CLK) hl++;
        bus.HLT = 1'b1;
        tick();
        if (bus.CLK) hl++;
        bus.HLT = 1'b0;
        for (int i = 0; i < 20 && bus.CLK; i++) begin
            tick();
            if (bus.CLK) hl++;
        end
        check("halt_high_len", hl, 8);
        check("halt_clk_low", int'(bus.CLK), 0);
        check("halt_halted", int'(bus.HALTED), 1);
        check("halt_busy", int'(bus.BUSY), 0);
        clear_meas();
        bus.CLK_STEP = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            observe();
        end
        bus.CLK_STEP = 1'b0;
        bus.MODE     = 2'b00;
        for (int i = 0; i < 50; i++) begin
            tick();
            observe();
        end
        check("halt_no_edges", m_edges, 0);
        check("halt_no_rise_pulse", m_rises, 0);
        check("halt_still_halted", int'(bus.HALTED), 1);
        rst_n = 1'b0;
        tick();
        check("halt_reset_clears", int'(bus.HALTED), 0);
        check("halt_reset_clk", int'(bus.CLK), 0);
        rst_n = 1'b1;

        // Reset in the middle of a burst
        bus.MODE      = 2'b10;
        bus.DIV_CLK   = 2'd0;
        bus.BURST_LEN = 4'd5;
        do_reset();
        bus.CLK_STEP = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.BUSY) found = 1'b1;
        end
        check("rstmid_burst_started", int'(found), 1);
        bus.CLK_STEP = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst_n = 1'b0;
        tick();
        check("rstmid_clk",      int'(bus.CLK),      0);
        check("rstmid_busy",     int'(bus.BUSY),     0);
        check("rstmid_not_clk",  int'(bus.NOT_CLK),  1);
        check("rstmid_clk_rise", int'(bus.CLK_RISE), 0);
        rst_n = 1'b1;
        clear_meas();
        for (int i = 0; i < 40; i++) begin
            tick();
            observe();
        end
        check("rstmid_no_partial", m_edges, 0);
        check("rstmid_idle_busy", m_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/be_clock_ctrl.md
BE_CLOCK_CTRL -- requirements
Module: be_clock_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, iCLK frequency in Hz.
REQ-002 SHALL have parameter BASE_HZ, default 1, slowest CLK rate (DIV_CLK=0).
REQ-003 SHALL have parameter DIV_W, default 3, width of DIV_CLK.
REQ-004 SHALL have parameter CNT_W, default 8, width of BURST_LEN.
REQ-005 SHALL have parameter DEB_CYCLES, default 500000, iCLK cycles CLK_STEP must be stable before it is accepted.
REQ-006 SHALL have port iCLK  input  1  board clock; the block's only clock.
REQ-007 SHALL have port iRST_N  input  1  reset, synchronous to iCLK, active-low.
REQ-008 SHALL have port MODE  input  2  00 continuous, 01 single-step, 10 burst, 11 stopped.
REQ-009 SHALL have port CLK_STEP  input  1  raw step push button, active high, asynchronous.
REQ-010 SHALL have port HLT  input  1  halt request from the computer, active high.
REQ-011 SHALL have port DIV_CLK  input  DIV_W  rate select; CLK rate = BASE_HZ * 2^DIV_CLK.
REQ-012 SHALL have port BURST_LEN  input  CNT_W  CLK periods per burst.
REQ-013 SHALL have port CLK  output  1  generated computer clock, registered.
REQ-014 SHALL have port NOT_CLK  output  1  always the inverse of CLK.
REQ-015 SHALL have port CLK_RISE  output  1  one-iCLK pulse in the same cycle CLK goes 0->1.
REQ-016 SHALL have port BUSY  output  1  high while a step or burst is in progress.
REQ-017 SHALL have port HALTED  output  1  high while the halt latch is set.

Function
REQ-018 SHALL derive a half-period length H = (CLK_HZ/(2*BASE_HZ)) >> DIV_CLK, counting 0..H-1 and raising a half-tick when the count reaches H-1.
REQ-019 SHALL sample DIV_CLK only at half-tick boundaries; a change mid-phase takes effect on the next phase.
REQ-020 SHALL treat H < 1 as a parameter error; the block supports H >= 1 for every DIV_CLK value only.
REQ-021 SHALL pass CLK_STEP through a 2-FF synchroniser and a debounce filter that accepts a new level after DEB_CYCLES consecutive equal samples; a step event is the accepted 0->1 transition.
REQ-022 SHALL implement the states IDLE, RUN, STEP_HI, STEP_LO, BURST and HALT.
REQ-023 SHALL toggle CLK at every half-tick in RUN, entered from IDLE when MODE=00.
REQ-024 SHALL, in IDLE with MODE=01, treat a step event as the start of one period: enter STEP_HI with CLK=1 for H cycles, then STEP_LO with CLK=0 for H cycles, then return to IDLE.
REQ-025 SHALL, in IDLE with MODE=10 and BURST_LEN>0, treat a step event as the start of a burst: load the count, then produce exactly BURST_LEN full periods starting high and ending low, then return to IDLE.
REQ-026 SHALL ignore a step event when BURST_LEN=0.
REQ-027 SHALL ignore step events while BUSY=1 or the state is RUN.
REQ-028 SHALL act on a MODE change only when CLK is low at a half-tick boundary, or while in IDLE, so that no high phase is truncated.
REQ-029 SHALL, in MODE=11, hold CLK low in IDLE.
REQ-030 SHALL set the halt latch when HLT=1 is sampled in any state.
REQ-031 SHALL, once the halt latch is set, finish any current high phase at its half-tick, then force CLK=0 and enter HALT.
REQ-032 SHALL hold HALT, ignoring steps and MODE, until iRST_N is asserted.
REQ-033 SHALL drive CLK_RISE high for exactly one iCLK cycle per CLK rising edge, and never in HALT.
REQ-034 SHALL hold BUSY high from the cycle after a step event until the return to IDLE.

Reset
REQ-035 SHALL, while iRST_N=0 at an iCLK edge, set CLK=0, NOT_CLK=1, CLK_RISE=0, BUSY=0, HALTED=0, all counters and the debounce state to 0, and the state to IDLE.
REQ-036 SHALL apply reset mid-step, mid-burst or in HALT identically, with no partial period emitted after reset releases.

Verification (CLK_HZ=16, BASE_HZ=1, DIV_W=2, CNT_W=4, DEB_CYCLES=4)
REQ-037 SHALL check: MODE=00, DIV_CLK=0 -> CLK toggles every 8 iCLK and NOT_CLK is its inverse; set DIV_CLK=3 -> toggles every 1 iCLK from the next boundary.
REQ-038 SHALL check: MODE=01, CLK_STEP high for 10 cycles -> exactly one period of 8 high and 8 low, one CLK_RISE pulse, and BUSY high for 16 cycles; a 2-cycle glitch -> no period.
REQ-039 SHALL check: MODE=10, BURST_LEN=3, step -> exactly 3 periods and 3 CLK_RISE pulses, then IDLE; BURST_LEN=0 -> nothing.
REQ-040 SHALL check: HLT pulsed 2 cycles into a high phase -> CLK stays high until the 8th cycle, then 0; HALTED=1; later steps and MODE=00 give no edges until iRST_N=0.
REQ-041 SHALL check: iRST_N=0 mid-burst -> next cycle CLK=0, BUSY=0, state IDLE; a MODE change during a high phase -> the phase completes its full 8 cycles.
